// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: a countdown per register tracks in-flight load destinations.
// Optional macro BRANCH_EX_HAZARD_EN adds a one-cycle stall for beq after a dependent ALU op.
module load_use_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [5:0]        id_op_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              flush_i,
    input  logic              mem_wait_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              idex_bubble_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned NumRegs = 1 << REG_AW;
    localparam logic [2:0]  LoadLat = 3'(LOAD_LAT);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    logic [2:0]       cnt_q [NumRegs];
    logic [2:0]       cnt_d [NumRegs];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic uses_rs, uses_rt, is_lw;
    logic src_busy, branch_haz, hazard, issue;

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_lw   = 1'b0;
        case (id_op_i)
            OpRtype, OpBeq, OpSw: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OpAddi: uses_rs = 1'b1;
            OpLw: begin
                uses_rs = 1'b1;
                is_lw   = 1'b1;
            end
            default: ;
        endcase
    end

    assign src_busy = (uses_rs && (id_rs_i != '0) && (cnt_q[id_rs_i] != 3'd0)) ||
                      (uses_rt && (id_rt_i != '0) && (cnt_q[id_rt_i] != 3'd0));

    assign hazard = id_valid_i & ~flush_i & (src_busy | branch_haz);
    assign issue  = id_valid_i & ~hazard & ~flush_i & ~mem_wait_i;

    assign hazard_o      = hazard;
    assign pc_stall_o    = hazard;
    assign ifid_stall_o  = hazard;
    assign idex_bubble_o = hazard;
    assign stall_cnt_o   = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!mem_wait_i && (cnt_q[r] != 3'd0)) begin
                cnt_d[r] = cnt_q[r] - 3'd1;
            end
        end
        // A new load overrides the decrement of the same register.
        if (issue && is_lw && (id_rt_i != '0)) begin
            cnt_d[id_rt_i] = LoadLat;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!mem_wait_i && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegs; r++) begin
                cnt_q[r] <= 3'd0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef BRANCH_EX_HAZARD_EN
    // The branch comparator sits in ID, so it cannot see an ALU result still in EX.
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic              ex_vld_q, ex_vld_d;

    always_comb begin
        ex_dst_d = ex_dst_q;
        ex_vld_d = ex_vld_q;
        if (!mem_wait_i) begin
            ex_vld_d = 1'b0;
            if (issue && (id_op_i == OpRtype)) begin
                ex_dst_d = id_rd_i;
                ex_vld_d = (id_rd_i != '0);
            end else if (issue && (id_op_i == OpAddi)) begin
                ex_dst_d = id_rt_i;
                ex_vld_d = (id_rt_i != '0);
            end
        end
    end

    assign branch_haz = (id_op_i == OpBeq) && ex_vld_q &&
                        ((id_rs_i == ex_dst_q) || (id_rt_i == ex_dst_q));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_dst_q <= '0;
            ex_vld_q <= 1'b0;
        end else begin
            ex_dst_q <= ex_dst_d;
            ex_vld_q <= ex_vld_d;
        end
    end
`else
    logic unused_rd;
    assign unused_rd  = ^id_rd_i;
    assign branch_haz = 1'b0;
`endif

endmodule
